// File: rtl/board_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : board_rx_pkg                                                 |
// | Description : Shared types and constants for the board-state frame         |
// |               receiver: frame geometry, row type and receive FSM states.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package board_rx_pkg;

  localparam int BOARD_ROWS      = 16;
  localparam int BOARD_COLS      = 8;
  localparam int BYTES_PER_FRAME = 16;
  localparam int FRAME_BITS      = BOARD_ROWS * BOARD_COLS;

  typedef logic [BOARD_COLS-1:0] row_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAP  = 3'd2,
    ST_GAP  = 3'd3,
    ST_SWAP = 3'd4
  } rx_state_t;

endpackage : board_rx_pkg
`default_nettype wire

// File: rtl/board_frame_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : board_frame_rx_if                                            |
// | Description : Read-strobe / byte-return link between the board-state       |
// |               producer and the frame receiver.                             |
// |   rd_req  : one-cycle read strobe (producer's read_gs input)               |
// |   rd_data : producer's registered byte output, valid one cycle after strobe|
// |   master  : receiver side (drives rd_req)                                  |
// |   slave   : producer side (drives rd_data)                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface board_frame_rx_if;
  import board_rx_pkg::*;

  logic rd_req;
  row_t rd_data;

  modport master (output rd_req, input rd_data);
  modport slave  (input rd_req, output rd_data);

endinterface : board_frame_rx_if
`default_nettype wire

// File: rtl/board_row_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : board_row_scanner                                            |
// | Description : Multiplexes the 128-bit display buffer onto an 8-column LED  |
// |               matrix, one row every SCAN_DIV cycles.                       |
// |   clock    in  1    clock                                                  |
// |   reset    in  1    synchronous active-high reset                          |
// |   disp     in  128  display buffer, row k at bits [8k+7:8k]                |
// |   row_sel  out 4    matrix row currently driven                            |
// |   row_data out 8    column bits for row_sel                                |
// | Build macro : BOARD_RX_VFLIP_EN - row_data shows display row 15-row_idx    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module board_row_scanner
  import board_rx_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] disp,
  output logic [3:0]            row_sel,
  output row_t                  row_data
);

  localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       row_idx_next;
  logic [3:0]       src_row;

  // row_sel doubles as row_idx; the next row and its data are loaded on the
  // same edge so the pair is always coherent.
  always_comb begin
    row_idx_next = row_sel + 4'd1;
`ifdef BOARD_RX_VFLIP_EN
    src_row = 4'd15 - row_idx_next;
`else
    src_row = row_idx_next;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt  <= '0;
      row_sel  <= '0;
      row_data <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      row_sel  <= row_idx_next;
      row_data <= disp[int'(src_row) * BOARD_COLS +: BOARD_COLS];
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule : board_row_scanner
`default_nettype wire

// File: rtl/board_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : board_frame_rx                                               |
// | Description : Polls the board-state producer with one-cycle read strobes,  |
// |               captures 16 rows per frame and swaps each completed frame    |
// |               into the display buffer driving the LED row scanner.         |
// |   clock       in  1   clock                                                |
// |   reset       in  1   synchronous active-high reset                        |
// |   run         in  1   enables polling, sampled in IDLE only                |
// |   bus         master  rd_req out / rd_data in                              |
// |   row_sel     out 4   matrix row currently driven                          |
// |   row_data    out 8   column bits for row_sel                              |
// |   frame_valid out 1   sticky, set after the first completed frame          |
// |   frame_cnt   out 8   completed-frame counter, wraps                       |
// | Build macro : BOARD_RX_VFLIP_EN - vertically flipped matrix output         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module board_frame_rx
  import board_rx_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  board_frame_rx_if.master  bus,
  output logic [3:0]        row_sel,
  output row_t              row_data,
  output logic              frame_valid,
  output logic [7:0]        frame_cnt
);

  localparam bit               HAS_GAP   = (POLL_GAP > 0);
  localparam int               GAP_W     = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [3:0]       LAST_BYTE = 4'(BYTES_PER_FRAME - 1);

  rx_state_t        state;
  rx_state_t        state_next;
  logic [3:0]       byte_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             cap_we;
  logic             swap;

  row_t                  cap_buf [BYTES_PER_FRAME];
  logic [FRAME_BITS-1:0] cap_flat;
  logic [FRAME_BITS-1:0] disp;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic. run is only looked at in IDLE so a started frame always
  // runs to 16 bytes and the producer's index stays aligned.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (run) state_next = ST_REQ;
      ST_REQ:  state_next = ST_CAP;
      ST_CAP: begin
        if (byte_cnt == LAST_BYTE) state_next = ST_SWAP;
        else if (HAS_GAP)          state_next = ST_GAP;
        else                       state_next = ST_REQ;
      end
      ST_GAP:  if (gap_cnt == GAP_LAST) state_next = ST_REQ;
      ST_SWAP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.rd_req = 1'b0;
    cap_we     = 1'b0;
    swap       = 1'b0;
    case (state)
      ST_REQ:  bus.rd_req = 1'b1;
      ST_CAP:  cap_we     = 1'b1;
      ST_SWAP: swap       = 1'b1;
      default: ;
    endcase
  end

  // Counters, display buffer and frame status
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      disp        <= '0;
      frame_cnt   <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                 gap_cnt <= '0;

      if (cap_we && (byte_cnt != LAST_BYTE)) byte_cnt <= byte_cnt + 4'd1;

      if (swap) begin
        byte_cnt    <= '0;
        disp        <= cap_flat;
        frame_cnt   <= frame_cnt + 8'd1;
        frame_valid <= 1'b1;
      end
    end
  end

  // Capture buffer is deliberately not reset; it is always fully rewritten
  // before it is ever swapped into the display buffer.
  always_ff @(posedge clock) begin
    if (cap_we) cap_buf[byte_cnt] <= bus.rd_data;
  end

  for (genvar k = 0; k < BOARD_ROWS; k++) begin : g_flat
    assign cap_flat[k*BOARD_COLS +: BOARD_COLS] = cap_buf[k];
  end

  board_row_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clock    (clock),
    .reset    (reset),
    .disp     (disp),
    .row_sel  (row_sel),
    .row_data (row_data)
  );

endmodule : board_frame_rx
`default_nettype wire

// File: tb/tb_board_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_board_frame_rx                                            |
// | Description : Self-checking bench for board_frame_rx with a producer model |
// |               and a frame-level reference of the displayed board.          |
// | Build macro : BOARD_RX_VFLIP_EN - expected rows are mirrored vertically    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_board_frame_rx;
  import board_rx_pkg::*;

  localparam int POLL_GAP = 4;
  localparam int SCAN_DIV = 2;
  localparam int SPACING  = POLL_GAP + 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b0;
  logic [3:0] row_sel;
  logic [7:0] row_data;
  logic       frame_valid;
  logic [7:0] frame_cnt;

  board_frame_rx_if bus ();

  board_frame_rx #(.POLL_GAP(POLL_GAP), .SCAN_DIV(SCAN_DIV)) dut (
    .clock(clock), .reset(reset), .run(run), .bus(bus),
    .row_sel(row_sel), .row_data(row_data),
    .frame_valid(frame_valid), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // Producer model: byte k of the current frame is prod_mem[k]
  logic [7:0] prod_mem [16];
  logic [7:0] exp_disp [16] = '{default: 8'h00};
  int   prod_idx    = 0;
  int   tot_strobes = 0;
  int   cyc         = 0;
  int   last_strobe = 0;
  int   gap_bad     = 0;
  int   req_double  = 0;
  logic prev_req    = 1'b0;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    prev_req <= bus.rd_req;
    if (bus.rd_req && prev_req) req_double <= req_double + 1;
    if (reset) begin
      prod_idx    <= 0;
      tot_strobes <= 0;
      bus.rd_data <= 8'h00;
    end else if (bus.rd_req) begin
      bus.rd_data <= prod_mem[prod_idx];
      prod_idx    <= (prod_idx + 1) % 16;
      tot_strobes <= tot_strobes + 1;
      if (prod_idx != 0 && (cyc - last_strobe) != SPACING) gap_bad <= gap_bad + 1;
      last_strobe <= cyc;
    end
  end

  function automatic int disp_idx(input logic [3:0] sel);
`ifdef BOARD_RX_VFLIP_EN
    return 15 - int'(sel);
`else
    return int'(sel);
`endif
  endfunction

  task automatic new_frame(input bit fixed);
    for (int k = 0; k < 16; k++)
      prod_mem[k] = fixed ? 8'(8'hA0 + k) : 8'($urandom);
  endtask

  // Raise run, drop it once drop_after strobes of this frame have issued.
  task automatic start_frame(input int drop_after, output bit ok);
    int t0;
    t0 = tot_strobes;
    ok = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (tot_strobes >= t0 + drop_after) begin ok = 1'b1; break; end
    end
    run = 1'b0;
  endtask

  // Wait for frame_cnt to move; row_moved reports a row update on that same edge.
  task automatic wait_frame(input int budget, output bit ok, output bit row_moved);
    logic [7:0] c0;
    logic [3:0] s_prev;
    c0 = frame_cnt;
    s_prev = row_sel;
    ok = 1'b0;
    row_moved = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (frame_cnt !== c0) begin ok = 1'b1; row_moved = (row_sel !== s_prev); break; end
      s_prev = row_sel;
    end
  endtask

  task automatic wait_row_update();
    logic [3:0] s0;
    s0 = row_sel;
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      @(negedge clock);
      if (row_sel !== s0) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (bus.rd_req !== 1'b0) begin fails++; $display("FAIL reset_rd_req: got %b want 0", bus.rd_req); end
    checks++; if (row_sel !== 4'd0) begin fails++; $display("FAIL reset_row_sel: got %0d want 0", row_sel); end
    checks++; if (row_data !== 8'h00) begin fails++; $display("FAIL reset_row_data: got %h want 00", row_data); end
    checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
    checks++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_frame();
    bit ok1, ok2, moved;
    int t0;
    new_frame(1'b1);
    t0 = tot_strobes;
    start_frame(1, ok1);
    wait_frame(300, ok2, moved);
    exp_disp = prod_mem;
    checks++; if (!(ok1 && ok2)) begin fails++; $display("FAIL single_timeout: start=%b frame=%b want 1 1", ok1, ok2); end
    checks++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL single_frame_valid: got %b want 1", frame_valid); end
    wait_row_update();
    for (int i = 0; i < 16 * SCAN_DIV; i++) begin
      checks++;
      if (row_data !== exp_disp[disp_idx(row_sel)]) begin
        fails++; $display("FAIL single_scan: row_sel=%0d row_data=%h want %h", row_sel, row_data, exp_disp[disp_idx(row_sel)]);
      end
      @(negedge clock);
    end
    repeat (20) @(negedge clock);
    checks++; if (tot_strobes - t0 !== 16) begin fails++; $display("FAIL single_strobes: got %0d want 16", tot_strobes - t0); end
    checks++; if (gap_bad !== 0) begin fails++; $display("FAIL strobe_spacing: %0d strobes not %0d cycles apart, want 0", gap_bad, SPACING); end
  endtask

  task automatic test_run_drop();
    bit ok1, ok2, moved;
    int t0, idle_req;
    new_frame(1'b0);
    t0 = tot_strobes;
    start_frame(5, ok1);
    wait_frame(300, ok2, moved);
    exp_disp = prod_mem;
    idle_req = 0;
    repeat (60) begin
      @(negedge clock);
      if (bus.rd_req) idle_req++;
    end
    checks++; if (!(ok1 && ok2)) begin fails++; $display("FAIL run_drop_timeout: start=%b frame=%b want 1 1", ok1, ok2); end
    checks++; if (tot_strobes - t0 !== 16) begin fails++; $display("FAIL run_drop_strobes: got %0d want 16", tot_strobes - t0); end
    checks++; if (idle_req !== 0) begin fails++; $display("FAIL run_drop_idle_req: got %0d strobes want 0", idle_req); end
    new_frame(1'b0);
    start_frame(1, ok1);
    wait_frame(300, ok2, moved);
    exp_disp = prod_mem;
    wait_row_update();
    for (int i = 0; i < 16 * SCAN_DIV; i++) begin
      checks++;
      if (row_data !== exp_disp[disp_idx(row_sel)]) begin
        fails++; $display("FAIL restart_scan: row_sel=%0d row_data=%h want %h", row_sel, row_data, exp_disp[disp_idx(row_sel)]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_swap_on_row_update();
    bit ok1, ok2, moved, hit;
    logic [7:0] old_disp [16];
    hit = 1'b0;
    // Growing start offsets cover both scan-divider phases whatever the frame length.
    for (int a = 0; a < 4 && !hit; a++) begin
      old_disp = exp_disp;
      new_frame(1'b0);
      for (int k = 0; k < 16; k++)
        if (prod_mem[k] == old_disp[k]) prod_mem[k] = ~old_disp[k];
      repeat (a) @(negedge clock);
      start_frame(1, ok1);
      wait_frame(300, ok2, moved);
      exp_disp = prod_mem;
      if (ok2 && moved) begin
        hit = 1'b1;
        checks++;
        if (row_data !== old_disp[disp_idx(row_sel)]) begin
          fails++; $display("FAIL swap_row_old: row_sel=%0d row_data=%h want %h", row_sel, row_data, old_disp[disp_idx(row_sel)]);
        end
        wait_row_update();
        checks++;
        if (row_data !== exp_disp[disp_idx(row_sel)]) begin
          fails++; $display("FAIL swap_row_new: row_sel=%0d row_data=%h want %h", row_sel, row_data, exp_disp[disp_idx(row_sel)]);
        end
      end
    end
    checks++; if (!hit) begin fails++; $display("FAIL swap_align: coincident swap found=%b want 1", hit); end
  endtask

  task automatic test_frame_wrap();
    bit done;
    done = 1'b0;
    new_frame(1'b0);
    run = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clock);
      if (tot_strobes > 0 && (tot_strobes % (16 * 256)) == 0) begin done = 1'b1; break; end
    end
    run = 1'b0;
    repeat (10) @(negedge clock);
    exp_disp = prod_mem;
    checks++; if (!done) begin fails++; $display("FAIL wrap_timeout: reached=%b want 1", done); end
    checks++; if (frame_cnt !== 8'((tot_strobes / 16) % 256)) begin
      fails++; $display("FAIL wrap_frame_cnt: got %0d want %0d", frame_cnt, (tot_strobes / 16) % 256);
    end
    checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL wrap_frame_valid: got %b want 1", frame_valid); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok1, ok2, moved;
    new_frame(1'b0);
    start_frame(9, ok1);   // returns during the 9th CAP cycle
    reset = 1'b1;
    @(negedge clock);
    checks++; if (!ok1) begin fails++; $display("FAIL midrst_timeout: got %b want 1", ok1); end
    checks++; if (bus.rd_req !== 1'b0) begin fails++; $display("FAIL midrst_rd_req: got %b want 0", bus.rd_req); end
    checks++; if (row_sel !== 4'd0) begin fails++; $display("FAIL midrst_row_sel: got %0d want 0", row_sel); end
    checks++; if (row_data !== 8'h00) begin fails++; $display("FAIL midrst_row_data: got %h want 00", row_data); end
    checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL midrst_frame_valid: got %b want 0", frame_valid); end
    checks++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL midrst_frame_cnt: got %0d want 0", frame_cnt); end
    @(negedge clock);
    reset = 1'b0;
    exp_disp = '{default: 8'h00};
    for (int i = 0; i < 16 * SCAN_DIV + 2; i++) begin
      @(negedge clock);
      checks++;
      if (row_data !== 8'h00) begin fails++; $display("FAIL midrst_zero_scan: row_sel=%0d row_data=%h want 00", row_sel, row_data); end
    end
    new_frame(1'b0);
    start_frame(1, ok1);
    wait_frame(300, ok2, moved);
    exp_disp = prod_mem;
    checks++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL midrst_next_cnt: got %0d want 1", frame_cnt); end
    wait_row_update();
    for (int i = 0; i < 16 * SCAN_DIV; i++) begin
      checks++;
      if (row_data !== exp_disp[disp_idx(row_sel)]) begin
        fails++; $display("FAIL midrst_next_scan: row_sel=%0d row_data=%h want %h", row_sel, row_data, exp_disp[disp_idx(row_sel)]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_strobe_rules();
    checks++; if (req_double !== 0) begin fails++; $display("FAIL rd_req_back_to_back: got %0d want 0", req_double); end
    checks++; if (gap_bad !== 0) begin fails++; $display("FAIL strobe_spacing_total: got %0d want 0", gap_bad); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) prod_mem[k] = 8'h00;
    test_reset();
    test_single_frame();
    test_run_drop();
    test_swap_on_row_update();
    test_frame_wrap();
    test_reset_mid_frame();
    test_strobe_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_board_frame_rx
`default_nettype wire
